// File: rtl/sprite_pkg.sv
// sprite_pkg: animation state type, coordinate width and frame-size helper
// shared by the sprite address generator and its animation sequencer.
package sprite_pkg;
    typedef enum logic {IDLE, PLAY} anim_state_t;
    localparam int COORD_W = 10;
    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction
endpackage

// File: rtl/sprite_anim_fsm.sv
// sprite_anim_fsm: play/stop animation sequencer; advances the displayed frame
// every TICKS_PER_FRAME video frames and keeps the frame's ROM base address.
module sprite_anim_fsm
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES      = 8,
    parameter int TICKS_PER_FRAME = 6,
    parameter int LOOP            = 1,
    parameter int FRAME_SIZE      = 6144,
    parameter int ADDR_W          = 16,
    parameter int IDX_W           = $clog2(NUM_FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              play,
    input  logic              stop,
    output logic              busy,
    output logic              anim_done,
    output logic [IDX_W-1:0]  frame_idx,
    output logic [ADDR_W-1:0] frame_base
);
    localparam int TICK_W = $clog2(TICKS_PER_FRAME > 1 ? TICKS_PER_FRAME : 2);

    anim_state_t       r_state, w_state;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt;
    logic [IDX_W-1:0]  r_frame_idx, w_frame_idx;
    logic [ADDR_W-1:0] r_frame_base, w_frame_base;
    logic              r_anim_done, w_anim_done;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_frame_idx  <= '0;
            r_frame_base <= '0;
            r_anim_done  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_tick_cnt   <= w_tick_cnt;
            r_frame_idx  <= w_frame_idx;
            r_frame_base <= w_frame_base;
            r_anim_done  <= w_anim_done;
        end
    end

    // stop outranks play and ticks; a request cycle never counts its tick
    always_comb begin
        w_state      = r_state;
        w_tick_cnt   = r_tick_cnt;
        w_frame_idx  = r_frame_idx;
        w_frame_base = r_frame_base;
        w_anim_done  = 1'b0;
        if (r_state == IDLE || stop) begin
            w_state      = (r_state == IDLE && play && !stop) ? PLAY : IDLE;
            w_tick_cnt   = '0;
            w_frame_idx  = '0;
            w_frame_base = '0;
        end else if (frame_tick) begin
            if (r_tick_cnt != TICK_W'(TICKS_PER_FRAME - 1)) begin
                w_tick_cnt = r_tick_cnt + TICK_W'(1);
            end else if (r_frame_idx != IDX_W'(NUM_FRAMES - 1)) begin
                w_tick_cnt   = '0;
                w_frame_idx  = r_frame_idx + IDX_W'(1);
                w_frame_base = r_frame_base + ADDR_W'(FRAME_SIZE);
            end else begin
                w_tick_cnt   = '0;
                w_frame_idx  = '0;
                w_frame_base = '0;
                w_state      = (LOOP != 0) ? PLAY : IDLE;
                w_anim_done  = (LOOP == 0);
            end
        end
    end

    assign busy       = (r_state == PLAY);
    assign anim_done  = r_anim_done;
    assign frame_idx  = r_frame_idx;
    assign frame_base = r_frame_base;
endmodule

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: maps VGA draw_x/draw_y onto the animated sprite ROM address.
// Define SPRITE_MIRROR_EN to add facing_left horizontal mirroring.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int FRAME_W         = 64,
    parameter int FRAME_H         = 96,
    parameter int NUM_FRAMES      = 8,
    parameter int TICKS_PER_FRAME = 6,
    parameter int LOOP            = 1,
    parameter int ADDR_W          = 16
) (
    input  logic                          vga_clk,
    input  logic                          reset_n,
    input  logic [COORD_W-1:0]            draw_x,
    input  logic [COORD_W-1:0]            draw_y,
    input  logic                          frame_tick,
    input  logic [COORD_W-1:0]            pos_x,
    input  logic [COORD_W-1:0]            pos_y,
    input  logic                          play,
    input  logic                          stop,
`ifdef SPRITE_MIRROR_EN
    input  logic                          facing_left,
`endif
    output logic                          busy,
    output logic                          anim_done,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic [ADDR_W-1:0]             rom_address,
    output logic                          sprite_on
);
    localparam int LW = $clog2(FRAME_W);

    logic [COORD_W:0]  w_dx, w_dy;
    logic              w_inside;
    logic [LW-1:0]     w_col;
    logic [ADDR_W-1:0] w_frame_base, w_addr;
    logic              r_sprite_on;
    logic [ADDR_W-1:0] r_rom_address;

    sprite_anim_fsm #(
        .NUM_FRAMES(NUM_FRAMES), .TICKS_PER_FRAME(TICKS_PER_FRAME), .LOOP(LOOP),
        .FRAME_SIZE(frame_size(FRAME_W, FRAME_H)), .ADDR_W(ADDR_W)
    ) u_fsm (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick), .play(play),
        .stop(stop), .busy(busy), .anim_done(anim_done), .frame_idx(frame_idx),
        .frame_base(w_frame_base)
    );

    // zero-extended subtraction: the extra top bit is the sign of the offset
    assign w_dx     = {1'b0, draw_x} - {1'b0, pos_x};
    assign w_dy     = {1'b0, draw_y} - {1'b0, pos_y};
    assign w_inside = !w_dx[COORD_W] && (w_dx[COORD_W-1:0] < COORD_W'(FRAME_W)) &&
                      !w_dy[COORD_W] && (w_dy[COORD_W-1:0] < COORD_W'(FRAME_H));
`ifdef SPRITE_MIRROR_EN
    assign w_col    = facing_left ? ~w_dx[LW-1:0] : w_dx[LW-1:0];
`else
    assign w_col    = w_dx[LW-1:0];
`endif
    assign w_addr   = w_frame_base + ((ADDR_W'(w_dy[COORD_W-1:0]) << LW) | ADDR_W'(w_col));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sprite_on   <= 1'b0;
            r_rom_address <= '0;
        end else begin
            r_sprite_on   <= w_inside;
            r_rom_address <= w_inside ? w_addr : '0;
        end
    end

    assign sprite_on   = r_sprite_on;
    assign rom_address = r_rom_address;
endmodule

// File: tb/tb_sprite_addr_gen.sv
// tb_sprite_addr_gen: looping and one-shot instances driven in parallel, checked
// against a tick-count model of the sprite animation and pixel addressing.
module tb_sprite_addr_gen;
    localparam int FW = 64, FH = 96, N = 8, T = 6;

    logic       vga_clk = 1'b0, reset_n = 1'b0;
    logic [9:0] draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
    logic       frame_tick = 1'b0, play = 1'b0, stop = 1'b0, facing_left = 1'b0;
    logic       busy_l, busy_o, done_l, done_o, on_l, on_o;
    logic [2:0] idx_l, idx_o;
    logic [15:0] addr_l, addr_o;

    int n_checks = 0, n_fail = 0, done_cnt = 0;
    bit m_play[2];
    int m_ticks[2];
    bit m_done[2];
    bit e_on;
    int e_addr[2];

    always #5 vga_clk = ~vga_clk;

    sprite_addr_gen #(.LOOP(1)) u_loop (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .play(play), .stop(stop),
`ifdef SPRITE_MIRROR_EN
        .facing_left(facing_left),
`endif
        .busy(busy_l), .anim_done(done_l), .frame_idx(idx_l), .rom_address(addr_l),
        .sprite_on(on_l)
    );

    sprite_addr_gen #(.LOOP(0)) u_once (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .play(play), .stop(stop),
`ifdef SPRITE_MIRROR_EN
        .facing_left(facing_left),
`endif
        .busy(busy_o), .anim_done(done_o), .frame_idx(idx_o), .rom_address(addr_o),
        .sprite_on(on_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_idx(input int i);
        return m_play[i] ? m_ticks[i] / T : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_play[i] = 0; m_ticks[i] = 0; m_done[i] = 0;
        end
    endtask

    // one clock: predict from current inputs, step the model, compare after the edge
    task automatic cycle();
        int dx, dy, col;
        dx = int'(draw_x) - int'(pos_x);
        dy = int'(draw_y) - int'(pos_y);
        e_on = dx >= 0 && dx < FW && dy >= 0 && dy < FH;
        col = dx;
`ifdef SPRITE_MIRROR_EN
        if (facing_left) col = FW - 1 - dx;
`endif
        for (int i = 0; i < 2; i++) begin
            e_addr[i] = e_on ? m_idx(i) * FW * FH + dy * FW + col : 0;
            m_done[i] = 0;
            if (!m_play[i]) begin
                if (play && !stop) begin m_play[i] = 1; m_ticks[i] = 0; end
            end else if (stop) begin
                m_play[i] = 0; m_ticks[i] = 0;
            end else if (frame_tick) begin
                m_ticks[i]++;
                if (m_ticks[i] == N * T) begin
                    m_ticks[i] = 0;
                    if (i == 1) begin m_play[i] = 0; m_done[i] = 1; end
                end
            end
        end
        @(posedge vga_clk);
        #1;
        check("on_loop", on_l, e_on);
        check("on_once", on_o, e_on);
        check("addr_loop", addr_l, e_addr[0]);
        check("addr_once", addr_o, e_addr[1]);
        check("busy_loop", busy_l, m_play[0]);
        check("busy_once", busy_o, m_play[1]);
        check("idx_loop", idx_l, m_idx(0));
        check("idx_once", idx_o, m_idx(1));
        check("done_loop", done_l, m_done[0]);
        check("done_once", done_o, m_done[1]);
        if (done_o) done_cnt++;
    endtask

    task automatic rst_check(input string tag);
        check({tag, "_on"}, {on_l, on_o}, 0);
        check({tag, "_addr"}, {addr_l, addr_o}, 0);
        check({tag, "_busy"}, {busy_l, busy_o}, 0);
        check({tag, "_idx"}, {idx_l, idx_o}, 0);
        check({tag, "_done"}, {done_l, done_o}, 0);
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1; cycle();
            frame_tick = 1'b0; cycle();
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge vga_clk);
        #1;
        rst_check("reset");
        reset_n = 1'b1;
        pos_x = 10'd100; pos_y = 10'd50; draw_x = 10'd100; draw_y = 10'd50;
        cycle();
        check("t1_on", on_l, 1);
        check("t1_addr0", addr_l, 0);
        draw_x = 10'd163; draw_y = 10'd145; cycle();
        check("t1_addr_last", addr_l, 6143);
        draw_x = 10'd99;  draw_y = 10'd50;  cycle(); check("t2_left", {on_l, addr_l}, 0);
        draw_x = 10'd164; draw_y = 10'd50;  cycle(); check("t2_right", {on_l, addr_l}, 0);
        draw_x = 10'd100; draw_y = 10'd146; cycle(); check("t2_below", {on_l, addr_l}, 0);
        pos_x = 10'd600; pos_y = 10'd470;
        draw_x = 10'd663; draw_y = 10'd479; cycle(); check("t2_edge", addr_l, 639);
        draw_x = 10'd5;   draw_y = 10'd5;   cycle(); check("t2_nowrap", on_l, 0);
        pos_x = 10'd100; pos_y = 10'd50; draw_x = 10'd100; draw_y = 10'd50;
        play = 1'b1; cycle(); play = 1'b0;
        tick_n(T);
        check("t3_idx", idx_l, 1);
        check("t3_addr", addr_l, 6144);
        check("t3_busy", busy_l, 1);
        stop = 1'b1; cycle(); stop = 1'b0;
        done_cnt = 0;
        play = 1'b1; cycle(); play = 1'b0;
        tick_n(N * T);
        cycle();
        check("t4_done_cnt", done_cnt, 1);
        check("t4_once_idle", {busy_o, idx_o}, 0);
        check("t4_loop_wrap", {busy_l, idx_l}, 4'b1000);
        play = 1'b1; stop = 1'b1; cycle(); play = 1'b0; stop = 1'b0;
        check("t5_stop_wins", {busy_l, idx_l}, 0);
        play = 1'b1; cycle(); play = 1'b0;
        tick_n(10);
        #2 reset_n = 1'b0;
        #1 rst_check("t5_async");
        m_reset();
        #3 reset_n = 1'b1;
`ifdef SPRITE_MIRROR_EN
        facing_left = 1'b1; draw_x = 10'd100; draw_y = 10'd50; cycle();
        check("t6_mirror", addr_l, 63);
`endif
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 63) == 0) begin
                pos_x = 10'($urandom); pos_y = 10'($urandom);
            end
            draw_x = pos_x + 10'($urandom_range(0, 80)) - 10'd8;
            draw_y = pos_y + 10'($urandom_range(0, 112)) - 10'd8;
            frame_tick  = ($urandom_range(0, 2) == 0);
            play        = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 79) == 0);
            facing_left = 1'($urandom);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
